// File: rtl/ucsbece154b_victim_pkg.sv
// Shared types and helpers for the victim-cache refill controller and its bench.
package ucsbece154b_victim_pkg;

  // Widths of the default victim cache configuration.
  localparam int VC_ADDR_WIDTH = 56;
  localparam int VC_LINE_WIDTH = 128;

  // Controller FSM states.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PROBE    = 3'd1,
    S_MEM_REQ  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_RESP     = 3'd4
  } vrc_state_e;

  // Number of byte-offset bits inside one cache line.
  function automatic int OFFSET_WIDTH(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  // One line transfer: address, payload and a qualifier.
  typedef struct packed {
    logic [VC_ADDR_WIDTH-1:0] addr;
    logic [VC_LINE_WIDTH-1:0] data;
    logic                     valid;
  } line_req_t;

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module ucsbece154b_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] r_count;

  // Count up on each increment request until every bit is set.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_count <= '0;
    end else if (inc_i && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/ucsbece154b_victim_refill_ctrl.sv
// L1 miss-side controller: probes the victim cache, writes the displaced line
// alongside the probe, and falls back to next-level memory on a victim miss.
module ucsbece154b_victim_refill_ctrl
  import ucsbece154b_victim_pkg::*;
#(
  parameter int ADDR_WIDTH = 56,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [ADDR_WIDTH-1:0] miss_addr_i,
  input  logic                  evict_valid_i,
  input  logic [ADDR_WIDTH-1:0] evict_addr_i,
  input  logic [LINE_WIDTH-1:0] evict_data_i,
  output logic                  refill_valid_o,
  input  logic                  refill_ready_i,
  output logic [LINE_WIDTH-1:0] refill_data_o,
  output logic                  refill_from_vc_o,
  output logic                  vc_en_o,
  output logic                  vc_flush_o,
  output logic [ADDR_WIDTH-1:0] vc_raddr_o,
  input  logic                  vc_hit_i,
  input  logic [LINE_WIDTH-1:0] vc_rdata_i,
  output logic                  vc_we_o,
  output logic [ADDR_WIDTH-1:0] vc_waddr_o,
  output logic [LINE_WIDTH-1:0] vc_wdata_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data_i,
  output logic [CNT_WIDTH-1:0]  hit_count_o,
  output logic [CNT_WIDTH-1:0]  miss_count_o
);

  localparam int OFF_W = OFFSET_WIDTH(LINE_WIDTH);

  vrc_state_e            r_state;
  vrc_state_e            w_state_next;
  logic [ADDR_WIDTH-1:0] r_miss_addr;
  logic                  r_evict_valid;
  logic [ADDR_WIDTH-1:0] r_evict_addr;
  logic [LINE_WIDTH-1:0] r_evict_data;
  logic [LINE_WIDTH-1:0] r_line;
  logic                  r_from_vc;
  logic                  r_vc_en;
  logic                  w_accept;
  logic                  w_probe_hit;
  logic                  w_probe_miss;
  logic                  w_rsp_take;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next    = r_state;
    miss_ready_o    = 1'b0;
    refill_valid_o  = 1'b0;
    vc_we_o         = 1'b0;
    mem_req_valid_o = 1'b0;
    w_accept        = 1'b0;
    w_probe_hit     = 1'b0;
    w_probe_miss    = 1'b0;
    w_rsp_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          w_accept     = 1'b1;
          w_state_next = S_PROBE;
        end
      end
      S_PROBE: begin
        // The victim write rides along with the probe; a flush wins over both.
        vc_we_o = r_evict_valid;
        if (vc_hit_i && !flush_i) begin
          w_probe_hit  = 1'b1;
          w_state_next = S_RESP;
        end else begin
          w_probe_miss = 1'b1;
          w_state_next = S_MEM_REQ;
        end
      end
      S_MEM_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) w_state_next = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_rsp_valid_i) begin
          w_rsp_take   = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        refill_valid_o = 1'b1;
        if (refill_ready_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latch the miss descriptor on accept and the refill line from its source.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_miss_addr   <= '0;
      r_evict_valid <= 1'b0;
      r_evict_addr  <= '0;
      r_evict_data  <= '0;
      r_line        <= '0;
      r_from_vc     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_miss_addr   <= miss_addr_i;
        r_evict_valid <= evict_valid_i;
        r_evict_addr  <= evict_addr_i;
        r_evict_data  <= evict_data_i;
      end
      if (w_probe_hit) begin
        r_line    <= vc_rdata_i;
        r_from_vc <= 1'b1;
      end else if (w_rsp_take) begin
        r_line    <= mem_rsp_data_i;
        r_from_vc <= 1'b0;
      end
    end
  end

  // Victim cache enable: a low enable wipes the cache, so it only drops in reset.
  always_ff @(posedge clk_i) begin
    r_vc_en <= !rst_i;
  end

  assign vc_en_o          = r_vc_en;
  assign vc_flush_o       = flush_i;
  assign vc_raddr_o       = r_miss_addr;
  assign vc_waddr_o       = r_evict_addr;
  assign vc_wdata_o       = r_evict_data;
  assign mem_req_addr_o   = {r_miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign refill_data_o    = r_line;
  assign refill_from_vc_o = r_from_vc;

  ucsbece154b_sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .inc_i   (w_probe_hit),
    .count_o (hit_count_o)
  );

  ucsbece154b_sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .inc_i   (w_probe_miss),
    .count_o (miss_count_o)
  );

endmodule

// File: tb/tb_ucsbece154b_victim_refill_ctrl.sv
// Directed bench for the victim refill controller with a 2-entry LRU victim
// cache model and a refill scoreboard.
module tb_ucsbece154b_victim_refill_ctrl;
  import ucsbece154b_victim_pkg::*;

  localparam int AW = 56;
  localparam int LW = 128;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          miss_valid_i = 1'b0;
  logic          miss_ready_o;
  logic [AW-1:0] miss_addr_i = '0;
  logic          evict_valid_i = 1'b0;
  logic [AW-1:0] evict_addr_i = '0;
  logic [LW-1:0] evict_data_i = '0;
  logic          refill_valid_o;
  logic          refill_ready_i = 1'b0;
  logic [LW-1:0] refill_data_o;
  logic          refill_from_vc_o;
  logic          vc_en_o;
  logic          vc_flush_o;
  logic [AW-1:0] vc_raddr_o;
  logic          vc_hit_i;
  logic [LW-1:0] vc_rdata_i;
  logic          vc_we_o;
  logic [AW-1:0] vc_waddr_o;
  logic [LW-1:0] vc_wdata_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i = 1'b0;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_rsp_valid_i = 1'b0;
  logic [LW-1:0] mem_rsp_data_i = '0;
  logic [CW-1:0] hit_count_o;
  logic [CW-1:0] miss_count_o;

  always #5 clk = ~clk;

  ucsbece154b_victim_refill_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_addr_i(miss_addr_i),
    .evict_valid_i(evict_valid_i), .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
    .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_data_o(refill_data_o), .refill_from_vc_o(refill_from_vc_o),
    .vc_en_o(vc_en_o), .vc_flush_o(vc_flush_o), .vc_raddr_o(vc_raddr_o),
    .vc_hit_i(vc_hit_i), .vc_rdata_i(vc_rdata_i),
    .vc_we_o(vc_we_o), .vc_waddr_o(vc_waddr_o), .vc_wdata_o(vc_wdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  // ---------------- 2-entry victim cache model (first match wins) ----------------
  logic [AW-1:0] m_tag [2];
  logic [LW-1:0] m_dat [2];
  logic [1:0]    m_v;
  logic          m_lru;
  logic          m_hit_way;
  logic          m_rd_en = 1'b0;
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [LW-1:0] pl_data = '0;

  always_comb begin
    vc_hit_i   = 1'b0;
    vc_rdata_i = '0;
    m_hit_way  = 1'b0;
    if (m_v[0] === 1'b1 && m_tag[0] == vc_raddr_o) begin
      vc_hit_i = 1'b1; vc_rdata_i = m_dat[0]; m_hit_way = 1'b0;
    end else if (m_v[1] === 1'b1 && m_tag[1] == vc_raddr_o) begin
      vc_hit_i = 1'b1; vc_rdata_i = m_dat[1]; m_hit_way = 1'b1;
    end
  end

  // Hit way goes MRU first, then any write lands in the LRU way.
  always @(posedge clk) begin
    logic lru_n;
    if (!vc_en_o || vc_flush_o) begin
      m_v   <= 2'b00;
      m_lru <= 1'b0;
    end else begin
      lru_n = m_lru;
      if (m_rd_en && vc_hit_i) lru_n = ~m_hit_way;
      if (vc_we_o) begin
        m_tag[lru_n] <= vc_waddr_o; m_dat[lru_n] <= vc_wdata_o; m_v[lru_n] <= 1'b1;
        lru_n = ~lru_n;
      end else if (pl_we) begin
        m_tag[lru_n] <= pl_addr; m_dat[lru_n] <= pl_data; m_v[lru_n] <= 1'b1;
        lru_n = ~lru_n;
      end
      m_lru <= lru_n;
    end
  end

  // Memory request handshake counter.
  int req_cnt = 0;
  always @(posedge clk) begin
    if (mem_req_valid_o && mem_req_ready_i) req_cnt <= req_cnt + 1;
  end

  // ---------------- scoreboard and checking ----------------
  typedef struct {
    logic [LW-1:0] data;
    logic          vc;
  } sb_t;
  sb_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic line_req_t mk_ev(input logic v, input logic [AW-1:0] a, input logic [LW-1:0] d);
    line_req_t r;
    r.addr = a; r.data = d; r.valid = v;
    return r;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [LW-1:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_we = 1'b0;
  endtask

  task automatic flush_idle();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hits"}, hit_count_o, exp_hits);
    check({tag, "_misses"}, miss_count_o, exp_misses);
  endtask

  // One full miss transaction, called from IDLE, #1 after an edge.
  task automatic do_miss(input string tag, input logic [AW-1:0] a, input line_req_t ev,
                         input logic exp_hit, input logic [LW-1:0] line,
                         input int req_stall, input int rdy_stall, input logic fl);
    sb_t e;
    sb_t got;
    int  req0;
    logic [AW-1:0] a_al;
    a_al = {a[AW-1:4], 4'h0};
    check({tag, "_idle_ready"}, miss_ready_o, 1'b1);
    miss_valid_i = 1'b1; miss_addr_i = a;
    evict_valid_i = ev.valid; evict_addr_i = ev.addr; evict_data_i = ev.data;
    e.data = line; e.vc = exp_hit;
    sb.push_back(e);
    req0 = req_cnt;
    step();
    miss_valid_i = 1'b0; miss_addr_i = '0;
    evict_valid_i = 1'b0; evict_addr_i = '0; evict_data_i = '0;
    m_rd_en = 1'b1; flush_i = fl;
    check({tag, "_probe_ready"}, miss_ready_o, 1'b0);
    check({tag, "_probe_raddr"}, vc_raddr_o, a);
    check({tag, "_probe_we"}, vc_we_o, ev.valid);
    if (ev.valid) begin
      check({tag, "_probe_waddr"}, vc_waddr_o, ev.addr);
      check({tag, "_probe_wdata"}, vc_wdata_o, ev.data);
    end
    check({tag, "_probe_flush"}, vc_flush_o, fl);
    check({tag, "_probe_refill"}, refill_valid_o, 1'b0);
    step();
    m_rd_en = 1'b0; flush_i = 1'b0;
    if (exp_hit) begin
      exp_hits = (exp_hits == 3) ? 3 : exp_hits + 1;
    end else begin
      exp_misses = (exp_misses == 3) ? 3 : exp_misses + 1;
      for (int i = 0; i < req_stall; i++) begin
        check({tag, "_req_valid"}, mem_req_valid_o, 1'b1);
        check({tag, "_req_addr"}, mem_req_addr_o, a_al);
        check({tag, "_req_busy"}, miss_ready_o, 1'b0);
        step();
      end
      check({tag, "_req_valid"}, mem_req_valid_o, 1'b1);
      check({tag, "_req_addr"}, mem_req_addr_o, a_al);
      mem_req_ready_i = 1'b1;
      step();
      mem_req_ready_i = 1'b0;
      check({tag, "_wait_noreq"}, mem_req_valid_o, 1'b0);
      check({tag, "_wait_norefill"}, refill_valid_o, 1'b0);
      step();
      mem_rsp_valid_i = 1'b1; mem_rsp_data_i = line;
      step();
      mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
    end
    check({tag, "_req_count"}, req_cnt - req0, exp_hit ? 0 : 1);
    for (int i = 0; i < rdy_stall; i++) begin
      check({tag, "_resp_hold_valid"}, refill_valid_o, 1'b1);
      check({tag, "_resp_hold_data"}, refill_data_o, line);
      check({tag, "_resp_busy"}, miss_ready_o, 1'b0);
      step();
    end
    check({tag, "_resp_valid"}, refill_valid_o, 1'b1);
    refill_ready_i = 1'b1;
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 1'b0, 1'b1);
    end else begin
      got = sb.pop_front();
      check({tag, "_refill_data"}, refill_data_o, got.data);
      check({tag, "_refill_from_vc"}, refill_from_vc_o, got.vc);
    end
    step();
    refill_ready_i = 1'b0;
    check({tag, "_done_norefill"}, refill_valid_o, 1'b0);
    check({tag, "_done_ready"}, miss_ready_o, 1'b1);
    check_counters(tag);
  endtask

  localparam logic [LW-1:0] D_A = {4{32'hA0A0_0001}};
  localparam logic [LW-1:0] D_B = {4{32'hB0B0_0002}};
  localparam logic [LW-1:0] D_C = {4{32'hC0C0_0003}};
  localparam logic [LW-1:0] D_D = {4{32'hD0D0_0004}};
  localparam logic [LW-1:0] D_E = {4{32'hE0E0_0005}};
  localparam logic [LW-1:0] D_F = {4{32'hF0F0_0006}};
  localparam logic [LW-1:0] D_G = {4{32'h1234_5678}};
  localparam logic [LW-1:0] D_H = {4{32'h8765_4321}};
  localparam logic [LW-1:0] D_I = {4{32'h5A5A_A5A5}};

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    line_req_t no_ev;
    no_ev = mk_ev(1'b0, '0, '0);
    #1;
    // Reset state
    step(); step();
    check("rst_vc_en_low", vc_en_o, 1'b0);
    check("rst_refill", refill_valid_o, 1'b0);
    check("rst_req", mem_req_valid_o, 1'b0);
    check("rst_we", vc_we_o, 1'b0);
    rst_i = 1'b0;
    step();
    check("post_rst_vc_en", vc_en_o, 1'b1);
    check("post_rst_ready", miss_ready_o, 1'b1);
    check_counters("post_rst");

    // Victim hit with no eviction: refill two edges after accept
    preload(56'h1000, D_A);
    do_miss("hit1", 56'h1000, no_ev, 1'b1, D_A, 0, 0, 1'b0);

    // Victim miss with eviction, then the evicted line hits
    do_miss("miss1", 56'h2000, mk_ev(1'b1, 56'h3000, D_B), 1'b0, D_C, 0, 0, 1'b0);
    do_miss("hit_evicted", 56'h3000, no_ev, 1'b1, D_B, 0, 0, 1'b0);

    // Backpressure on request and refill, unaligned miss address
    do_miss("bp", 56'h7008, no_ev, 1'b0, D_G, 5, 3, 1'b0);

    // Hit on the LRU way while evicting: hit survives, other way is replaced
    flush_idle();
    check("flushed_empty", m_v, 2'b00);
    preload(56'h4000, D_D);
    preload(56'h5000, D_E);
    do_miss("lru_hit", 56'h4000, mk_ev(1'b1, 56'h6000, D_F), 1'b1, D_D, 0, 1, 1'b0);
    check("lru_way0_tag", m_tag[0], 56'h4000);
    check("lru_way1_tag", m_tag[1], 56'h6000);
    check("lru_way1_data", m_dat[1], D_F);
    do_miss("hit_sat", 56'h6000, no_ev, 1'b1, D_F, 0, 0, 1'b0);

    // Flush during PROBE of a would-be hit
    do_miss("flush_probe", 56'h4000, mk_ev(1'b1, 56'hA000, D_A), 1'b0, D_H, 1, 0, 1'b1);
    check("flush_vc_empty", m_v, 2'b00);
    do_miss("miss_sat", 56'h8000, no_ev, 1'b0, D_I, 0, 0, 1'b0);

    // Reset while waiting for memory, then a stray response
    miss_valid_i = 1'b1; miss_addr_i = 56'h9000;
    step();
    miss_valid_i = 1'b0; miss_addr_i = '0;
    step();
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    check("mw_noreq", mem_req_valid_o, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mw_rst_vc_en_low", vc_en_o, 1'b0);
    check("mw_rst_ready", miss_ready_o, 1'b1);
    exp_hits = 0; exp_misses = 0;
    check_counters("mw_rst");
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = D_C;
    step();
    mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
    check("mw_vc_en_high", vc_en_o, 1'b1);
    check("mw_stray_refill", refill_valid_o, 1'b0);
    step();
    check("mw_stray_refill2", refill_valid_o, 1'b0);
    check("mw_idle_ready", miss_ready_o, 1'b1);
    check("mw_noreq2", mem_req_valid_o, 1'b0);
    check_counters("mw_end");
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_victim_refill_ctrl.md
Name: ucsbece154b_victim_refill_ctrl

Overview:
Miss-side controller that drives the victim cache's read and write ports on behalf of the L1.
- On each accepted L1 miss it probes the victim cache with the miss address.
- In the same cycle it writes the line the L1 is displacing into the victim cache.
- On a victim hit it returns the victim cache line; on a victim miss it fetches the line from next-level memory.
- It sits between the L1 miss handler, the victim cache and the memory request/response interface, and keeps hit and miss statistics.

Parameters:
ADDR_WIDTH, 56, byte address width; matches victim cache.
LINE_WIDTH, 128, line width in bits; offset bits = clog2(LINE_WIDTH/8).
CNT_WIDTH, 32, width of the hit/miss statistic counters.

Ports:
clk_i  in  1  clock; one clock.
rst_i  in  1  reset; synchronous and active-high.
flush_i  in  1  flush request from core.
miss_valid_i  in  1  L1 miss request valid.
miss_ready_o  out  1  controller can accept a miss.
miss_addr_i  in  ADDR_WIDTH  missing line address.
evict_valid_i  in  1  a valid line is displaced with this miss.
evict_addr_i  in  ADDR_WIDTH  displaced line address.
evict_data_i  in  LINE_WIDTH  displaced line data.
refill_valid_o  out  1  refill line available.
refill_ready_i  in  1  L1 accepts refill.
refill_data_o  out  LINE_WIDTH  refill line.
refill_from_vc_o  out  1  refill was sourced from the victim cache.
vc_en_o  out  1  victim cache enable.
vc_flush_o  out  1  victim cache flush.
vc_raddr_o  out  ADDR_WIDTH  victim cache read address.
vc_hit_i  in  1  victim cache hit (combinational on vc_raddr_o).
vc_rdata_i  in  LINE_WIDTH  victim cache read data.
vc_we_o  out  1  victim cache write enable.
vc_waddr_o  out  ADDR_WIDTH  victim cache write address.
vc_wdata_o  out  LINE_WIDTH  victim cache write data.
mem_req_valid_o  out  1  memory line request valid.
mem_req_ready_i  in  1  memory accepts request.
mem_req_addr_o  out  ADDR_WIDTH  line-aligned request address (offset bits zero).
mem_rsp_valid_i  in  1  memory response valid (one-cycle pulse, always accepted).
mem_rsp_data_i  in  LINE_WIDTH  memory response line.
hit_count_o  out  CNT_WIDTH  saturating count of victim hits.
miss_count_o  out  CNT_WIDTH  saturating count of victim misses.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; miss_ready_o=1; refill_valid_o=0; mem_req_valid_o=0; vc_we_o=0; vc_en_o=0; counters 0; latched registers 0.
- vc_en_o is registered: 0 while rst_i is high, 1 from the first cycle after reset. It is never dropped otherwise, because a low enable clears the victim cache.
- vc_flush_o = flush_i, combinational.
- FSM states: IDLE, PROBE, MEM_REQ, MEM_WAIT, RESP.
- IDLE:
  - miss_ready_o=1.
  - On miss_valid_i, latch miss_addr, evict_valid, evict_addr and evict_data, then go to PROBE.
  - miss_ready_o=0 in all other states.
- PROBE (exactly 1 cycle):
  - vc_raddr_o = latched miss address.
  - vc_we_o = latched evict_valid, with vc_waddr_o/vc_wdata_o = latched evict fields.
  - Same-cycle read and write are legal: the hit way is bumped to MRU before the LRU is replaced, so the write never clobbers the hit line.
  - If vc_hit_i is 1 and flush_i is 0: latch vc_rdata_i, set from_vc=1, increment hit_count, go to RESP.
  - Otherwise: increment miss_count, go to MEM_REQ.
  - A flush in PROBE forces the miss path; the victim write is discarded by the flush.
- MEM_REQ:
  - mem_req_valid_o=1 and mem_req_addr_o held stable until mem_req_ready_i, then go to MEM_WAIT.
  - mem_req_ready_i in the same cycle valid rises counts as acceptance.
- MEM_WAIT: on mem_rsp_valid_i, latch data, set from_vc=0, go to RESP.
- RESP: refill_valid_o=1 with data and from_vc held stable until refill_ready_i; then go to IDLE (the next miss can be accepted on the following cycle).
- Hit latency: miss accepted at edge N; refill_valid_o is high in cycle N+2.
- Counters saturate at all-ones and never wrap.
- Residency: the hit line stays resident in the victim cache (non-exclusive). Duplicate tags are tolerated because the victim cache returns the first match.
- Reset in any state returns to IDLE and clears all outputs. A memory response arriving after reset is ignored in IDLE.
- mem_rsp_valid_i outside MEM_WAIT is ignored.
- refill_ready_i outside RESP is ignored.

Decomposition:
- Package ucsbece154b_victim_pkg holds:
  - state enum vrc_state_e;
  - OFFSET_WIDTH function of LINE_WIDTH;
  - a line_req_t struct (addr, data, valid), shared with the victim cache bench.
- Sub-module ucsbece154b_sat_counter (parameterized width, synchronous active-high clear, increment enable), instantiated twice.

Test Plan:
- Victim hit: preload the victim cache with addr 0x1000/data A, then miss 0x1000 with no eviction -> refill_valid_o at N+2, data A, from_vc=1, no mem request, hit_count=1.
- Victim miss: miss 0x2000 with evict 0x3000/B -> vc_we_o pulse in PROBE with waddr 0x3000; mem_req_addr_o=0x2000; after response C, refill C with from_vc=0; miss_count=1; a later miss 0x3000 hits with data B.
- Backpressure: hold mem_req_ready_i low 5 cycles, then refill_ready_i low 3 cycles -> valid and addr/data stable throughout; exactly one request; miss_ready_o=0 until RESP completes.
- Eviction of the hit way: victim cache entries=2, both full, miss the LRU-way address with an eviction -> hit returns the old data; the evicted line replaces the other way.
- Flush in PROBE on a would-be hit -> treated as a miss; memory fetched; victim cache empty afterwards.
- Reset asserted in MEM_WAIT, then a stray mem_rsp_valid_i -> IDLE, no refill_valid_o, counters 0, vc_en_o low for the reset cycle and high afterwards.
